// File: rtl/marker_centroid.sv
// rtl/marker_centroid.sv - per-colour marker centre of mass with one shared restoring divider
// Optional feature macro: MARKER_CENTROID_SMOOTH_EN (averages each new centroid with the previous one).
module marker_centroid #(
    parameter int MIN_PIXELS = 16,
    parameter int COUNT_W    = 20,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        valid_in,
    input  logic [3:0]  mask_in,
    input  logic        tabulate_in,
    output logic [10:0] red_x_com,
    output logic [10:0] purple_x_com,
    output logic [10:0] green_x_com,
    output logic [10:0] blue_x_com,
    output logic [9:0]  red_y_com,
    output logic [9:0]  purple_y_com,
    output logic [9:0]  green_y_com,
    output logic [9:0]  blue_y_com,
    output logic        valid_red,
    output logic        valid_purple,
    output logic        valid_green,
    output logic        valid_blue,
    output logic        busy_out
);
    localparam int DW  = DIV_CYCLES;
    localparam int DCW = $clog2(DIV_CYCLES + 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, STORE, OUT} state_t;
    state_t state, state_nx;

    logic [3:0][COUNT_W-1:0] cnt, cnt_nx, cnt_snap;
    logic [3:0][DW-1:0]      sx, sy, sx_nx, sy_nx, sx_snap, sy_snap;
    logic                    take;
    logic [2:0]              job;
    logic [1:0]              job_col;
    logic [DCW-1:0]          div_cnt;
    logic [DW-1:0]           quo;
    logic [COUNT_W-1:0]      rem, dvs;
    logic [COUNT_W:0]        rem_sh;
    logic                    ge;
    logic [3:0][10:0]        res_x, com_x;
    logic [3:0][9:0]         res_y, com_y;
    logic [3:0]              valid_q;
`ifdef MARKER_CENTROID_SMOOTH_EN
    logic [3:0]              seen;
`endif

    // A frame-end strobe only takes effect when no computation is in flight.
    assign take    = tabulate_in && (state == IDLE);
    // Jobs run red x, red y, purple x, ... so the colour is the upper two bits of the job number.
    assign job_col = job[2:1];

    // Next accumulator values including this edge's pixel; a saturated colour is frozen.
    always_comb begin
        cnt_nx = cnt;
        sx_nx  = sx;
        sy_nx  = sy;
        for (int c = 0; c < 4; c++) begin
            if (valid_in && mask_in[c] && (cnt[c] != {COUNT_W{1'b1}})) begin
                cnt_nx[c] = cnt[c] + COUNT_W'(1);
                sx_nx[c]  = sx[c] + DW'(x_in);
                sy_nx[c]  = sy[c] + DW'(y_in);
            end
        end
    end

    // Live accumulators and the frame snapshot; a coincident pixel lands in the snapshot.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt      <= '0;
            sx       <= '0;
            sy       <= '0;
            cnt_snap <= '0;
            sx_snap  <= '0;
            sy_snap  <= '0;
        end else if (take) begin
            cnt_snap <= cnt_nx;
            sx_snap  <= sx_nx;
            sy_snap  <= sy_nx;
            cnt      <= '0;
            sx       <= '0;
            sy       <= '0;
        end else begin
            cnt <= cnt_nx;
            sx  <= sx_nx;
            sy  <= sy_nx;
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic: eight load/divide/store jobs, then one output cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tabulate_in) state_nx = LOAD;
            LOAD:    state_nx = DIV;
            DIV:     if (div_cnt == DIV_LAST) state_nx = STORE;
            STORE:   state_nx = (job == 3'd7) ? OUT : LOAD;
            OUT:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Restoring divider step: shift the next dividend bit into the partial remainder.
    always_comb begin
        rem_sh = {rem, quo[DW-1]};
        ge     = (rem_sh >= {1'b0, dvs});
    end

    // Divider datapath and per-job result capture.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            job     <= '0;
            div_cnt <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            res_x   <= '0;
            res_y   <= '0;
        end else begin
            case (state)
                IDLE: job <= '0;
                LOAD: begin
                    quo     <= job[0] ? sy_snap[job_col] : sx_snap[job_col];
                    dvs     <= cnt_snap[job_col];
                    rem     <= '0;
                    div_cnt <= '0;
                end
                DIV: begin
                    quo     <= {quo[DW-2:0], ge};
                    rem     <= ge ? COUNT_W'(rem_sh - {1'b0, dvs}) : rem_sh[COUNT_W-1:0];
                    div_cnt <= div_cnt + DCW'(1);
                end
                STORE: begin
                    if (job[0]) begin
                        res_y[job_col] <= (dvs == '0) ? 10'd0 : quo[9:0];
                    end else begin
                        res_x[job_col] <= (dvs == '0) ? 11'd0 : quo[10:0];
                    end
                    job <= job + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Output registers: publish centroids and pulse valids for colours above threshold.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            com_x    <= '0;
            com_y    <= '0;
            valid_q  <= '0;
            busy_out <= 1'b0;
`ifdef MARKER_CENTROID_SMOOTH_EN
            seen     <= '0;
`endif
        end else begin
            busy_out <= (state != IDLE);
            valid_q  <= '0;
            if (state == OUT) begin
                for (int c = 0; c < 4; c++) begin
                    if (cnt_snap[c] >= COUNT_W'(MIN_PIXELS)) begin
                        valid_q[c] <= 1'b1;
`ifdef MARKER_CENTROID_SMOOTH_EN
                        seen[c] <= 1'b1;
                        if (seen[c]) begin
                            com_x[c] <= 11'(({1'b0, com_x[c]} + {1'b0, res_x[c]}) >> 1);
                            com_y[c] <= 10'(({1'b0, com_y[c]} + {1'b0, res_y[c]}) >> 1);
                        end else begin
                            com_x[c] <= res_x[c];
                            com_y[c] <= res_y[c];
                        end
`else
                        com_x[c] <= res_x[c];
                        com_y[c] <= res_y[c];
`endif
                    end
                end
            end
        end
    end

    assign red_x_com    = com_x[0];
    assign purple_x_com = com_x[1];
    assign green_x_com  = com_x[2];
    assign blue_x_com   = com_x[3];
    assign red_y_com    = com_y[0];
    assign purple_y_com = com_y[1];
    assign green_y_com  = com_y[2];
    assign blue_y_com   = com_y[3];
    assign valid_red    = valid_q[0];
    assign valid_purple = valid_q[1];
    assign valid_green  = valid_q[2];
    assign valid_blue   = valid_q[3];

endmodule

// File: doc/marker_centroid.md
Name: marker_centroid

Overview:
- Accumulates per-colour pixel coordinates from the colour-mask pixel stream over one frame.
- On the frame-end strobe, computes each marker's centre of mass (red, purple, green, blue) with one shared iterative divider.
- Produces the `*_x_com` / `*_y_com` / `valid_*` interface consumed by the ball-vector block.
- Sits between the colour-threshold stage and the vector/geometry stage.

Parameters:
- MIN_PIXELS, 16: minimum matching pixel count for a colour's centroid to be reported valid.
- COUNT_W, 20: width of the per-colour pixel counters.
- DIV_CYCLES, 32: iterations of the restoring divider; equals the dividend width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- x_in  input  11  pixel column.
- y_in  input  10  pixel row.
- valid_in  input  1  pixel qualifier.
- mask_in  input  4  per-pixel colour match: bit0 red, bit1 purple, bit2 green, bit3 blue; several bits may be set at once.
- tabulate_in  input  1  frame-end strobe.
- red_x_com, purple_x_com, green_x_com, blue_x_com  output  11 each  centroid column.
- red_y_com, purple_y_com, green_y_com, blue_y_com  output  10 each  centroid row.
- valid_red, valid_purple, valid_green, valid_blue  output  1 each  one-cycle result pulse.
- busy_out  output  1  high while results are being computed.

Behaviour:
- Reset: all accumulators, outputs, `busy_out` and the state register go to 0; state is IDLE.
- Accumulation:
  - On each edge with `valid_in=1`, for every set `mask_in` bit c: `cnt[c]+=1`, `sx[c]+=x_in`, `sy[c]+=y_in`.
  - `sx` and `sy` are 32-bit unsigned.
  - When `cnt[c]` reaches 2^COUNT_W-1, colour c stops accumulating (count and sums frozen) until the next snapshot.
- Snapshot:
  - On an edge with `tabulate_in=1` in IDLE, all `cnt`/`sx`/`sy` are copied to snapshot registers and the live accumulators are cleared.
  - A pixel presented in the same cycle as `tabulate_in` belongs to the snapshotted frame.
  - Accumulation of the next frame continues during computation.
- tabulate_in while busy: ignored. No snapshot, no clear; accumulators keep growing into the following frame.
- FSM: IDLE -> LOAD -> DIV -> STORE -> (LOAD | OUT) -> IDLE.
  - LOAD (1 cycle): select job j of 0..7, ordered red x, red y, purple x, purple y, green x, green y, blue x, blue y; load dividend = `sx`/`sy` snapshot, divisor = `cnt` snapshot.
  - DIV (DIV_CYCLES cycles): restoring shift-subtract, one quotient bit per cycle, MSB first.
  - STORE (1 cycle):
    - Write the quotient's low 11 bits (x jobs) or low 10 bits (y jobs) into an internal result register.
    - If the divisor is 0, store 0.
    - If j=7, go to OUT; else j+=1 and go to LOAD.
  - OUT (1 cycle):
    - Copy internal results to the `*_com` outputs.
    - Assert `valid_c = (cnt_snapshot[c] >= MIN_PIXELS)` for exactly this cycle; all four valids are simultaneous.
    - For colours below threshold, the com outputs hold their previous values.
- Latency: tabulate sampled at edge T gives valid pulses high during the cycle after edge T+8*(DIV_CYCLES+2)+1, i.e. edge T+273 with defaults.
- busy_out: high from edge T+1 through the OUT cycle inclusive.
- Quotient is floor division. An average never exceeds the coordinate range, so no saturation is needed.
- Asynchronous reset mid-computation aborts the job; no valid pulse is produced for that frame.

Optional Feature:
- Macro: MARKER_CENTROID_SMOOTH_EN.
- Defined: for each colour reported valid, `com_out <= (com_prev + com_new) >> 1` (floor), computed in OUT. The first valid result after reset is loaded unsmoothed, tracked per colour by a seen flag cleared on reset.
- Undefined: `com_out <= com_new` directly; no seen flags exist.

Test Plan:
- Reset then idle: all outputs are 0, `busy_out=0`, no valid pulses for 500 cycles.
- 16 red pixels at (300,300) and 16 at (302,304), then tabulate -> at T+273 `valid_red=1` for exactly one cycle, com=(301,302); other valids 0.
- Red pixels (299,300) and (300,301), 8 copies each, with MIN_PIXELS=16 -> com=(299,300) (floor); a pixel with `mask_in=4'b1111` at (400,200) ×16 gives all four colours (400,200).
- Blue only 5 pixels -> `valid_blue=0`, blue com unchanged. Zero pixels for a colour -> no valid and no divide fault.
- Second tabulate at T+100 is ignored; pixels fed during busy appear in the next frame's result; a pixel coincident with tabulate is counted in the old frame.
- Reset asserted at T+150 -> outputs 0, no pulse. With MARKER_CENTROID_SMOOTH_EN: red (300,300) then (310,310) yields (300,300) then (305,305).
